pc_sequencer: RTL

Owns the program counter of the interpolation ASIP and sequences instruction fetch. It takes branch and jump requests plus the eq/bgt flags from the execute stage, stalls from the hazard unit, and halt/resume control. It produces the fetch address, the fetch enable, and the pipeline flush strobes. It sits between the decode/execute control and the instruction memory, and replaces the free-running PC register.

---
 rtl/pc_seq_pkg.sv | 29 ++
 rtl/pc_redirect_deco.sv | 69 ++++++
 rtl/pc_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-counter sequencer of the interpolation
// ASIP: the sequencer state enum and the encodings of the branch and jump
// select fields coming from decode/execute.
// No ports (package). Optional feature macro used by the block: PC_PERF_CNT_EN.
// ---------------------------------------------------------------------------
package pc_seq_pkg;

    // Sequencer states: IDLE only lasts until the first edge after reset.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // Branch select encodings
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BE   = 2'b01;
    localparam logic [1:0] BR_BGT  = 2'b10;
    localparam logic [1:0] BR_ILL  = 2'b11;

    // Jump select encodings
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_IMM  = 2'b01;
    localparam logic [1:0] JMP_REG  = 2'b10;
    localparam logic [1:0] JMP_ILL  = 2'b11;

endpackage

// File: rtl/pc_redirect_deco.sv
// ---------------------------------------------------------------------------
// pc_redirect_deco
// Purely combinational redirect decoder. Turns the branch/jump selects and
// the execute-stage compare flags into a redirect request, an aligned target
// address, an illegal-select indication and a misaligned-target indication.
// The outputs are raw: the sequencer gates them with its own state.
//
// Ports:
//   branch_sel  in  2   branch select (none/BE/BGT/illegal)
//   jmp_sel     in  2   jump select (none/imm/reg/illegal)
//   eq, bgt     in  1   compare flags
//   addr_b/i/r  in  AW  branch, immediate-jump and register-jump targets
//   redirect    out 1   a taken branch or a jump is requested
//   target      out AW  selected target with its low alignment bits cleared
//   illegal     out 1   illegal select combination
//   misaligned  out 1   selected target had non-zero alignment bits
// ---------------------------------------------------------------------------
module pc_redirect_deco
    import pc_seq_pkg::*;
#(
    parameter int unsigned AW   = 32,
    parameter int unsigned STEP = 4
) (
    input  logic [1:0]    branch_sel,
    input  logic [1:0]    jmp_sel,
    input  logic          eq,
    input  logic          bgt,
    input  logic [AW-1:0] addr_b,
    input  logic [AW-1:0] addr_i,
    input  logic [AW-1:0] addr_r,
    output logic          redirect,
    output logic [AW-1:0] target,
    output logic          illegal,
    output logic          misaligned
);

    // STEP is a power of two, so STEP-1 masks exactly the low log2(STEP) bits.
    localparam logic [AW-1:0] ALIGN_MASK = AW'(STEP - 1);

    logic          takenB;
    logic          jumpReq;
    logic [AW-1:0] rawTarget;

    // Decode the request. Any illegal select, including a branch and a jump
    // requested together, suppresses the redirect entirely.
    always_comb begin
        takenB    = ((branch_sel == BR_BE) && eq) || ((branch_sel == BR_BGT) && bgt);
        illegal   = (branch_sel == BR_ILL) || (jmp_sel == JMP_ILL) ||
                    ((branch_sel != BR_NONE) && (jmp_sel != JMP_NONE));
        jumpReq   = 1'b0;
        rawTarget = addr_b;
        case (jmp_sel)
            JMP_IMM: begin
                jumpReq   = 1'b1;
                rawTarget = addr_i;
            end
            JMP_REG: begin
                jumpReq   = 1'b1;
                rawTarget = addr_r;
            end
            default: begin
            end
        endcase
        redirect   = !illegal && (jumpReq || takenB);
        target     = rawTarget & ~ALIGN_MASK;
        misaligned = redirect && ((rawTarget & ALIGN_MASK) != '0);
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter of the interpolation ASIP and sequences
// instruction fetch. Applies branch/jump redirects (with same-cycle pipeline
// flushes), hazard stalls and halt/resume control.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   branch_sel, jmp_sel branch/jump selects from decode/execute
//   eq, bgt             execute-stage compare flags
//   addr_b/i/r          branch, immediate-jump and register-jump targets
//   stall               hazard unit: hold PC this cycle
//   halt, resume        enter / leave HALT (level-sampled)
//   pc                  current fetch address
//   fetch_en            instruction memory read enable (state RUN)
//   flush_if_id/id_ex   squash younger pipeline registers (same cycle as redirect)
//   redirect            taken branch or jump applied this cycle
//   illegal             illegal select combination this cycle
//   misaligned          selected target had non-zero low log2(STEP) bits
//   redirect_cnt        (PC_PERF_CNT_EN only) saturating redirect-cycle count
//   stall_cnt           (PC_PERF_CNT_EN only) saturating stalled-RUN-cycle count
//
// Optional feature macro: PC_PERF_CNT_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned   AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int unsigned   STEP     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    branch_sel,
    input  logic [1:0]    jmp_sel,
    input  logic          eq,
    input  logic          bgt,
    input  logic [AW-1:0] addr_b,
    input  logic [AW-1:0] addr_i,
    input  logic [AW-1:0] addr_r,
    input  logic          stall,
    input  logic          halt,
    input  logic          resume,
    output logic [AW-1:0] pc,
    output logic          fetch_en,
    output logic          flush_if_id,
    output logic          flush_id_ex,
    output logic          redirect,
    output logic          illegal,
    output logic          misaligned
`ifdef PC_PERF_CNT_EN
    ,
    output logic [15:0]   redirect_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    localparam logic [AW-1:0] STEP_W = AW'(STEP);

    pc_state_e     state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;

    logic          decoRedirect;
    logic [AW-1:0] decoTarget;
    logic          decoIllegal;
    logic          decoMisaligned;

    pc_redirect_deco #(
        .AW   (AW),
        .STEP (STEP)
    ) u_deco (
        .branch_sel (branch_sel),
        .jmp_sel    (jmp_sel),
        .eq         (eq),
        .bgt        (bgt),
        .addr_b     (addr_b),
        .addr_i     (addr_i),
        .addr_r     (addr_r),
        .redirect   (decoRedirect),
        .target     (decoTarget),
        .illegal    (decoIllegal),
        .misaligned (decoMisaligned)
    );

    // State and PC registers. Reset drops any pending redirect because the
    // registers are forced before the next edge can load a target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state logic. In RUN, a redirect or stall outranks halt, so halt
    // only takes effect on an otherwise sequential cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (!decoRedirect && !stall && halt) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next-PC selection: redirect > stall > halt > sequential, only in RUN.
    // IDLE keeps RESET_PC so it is the first address fetched.
    always_comb begin
        pc_d = pc_q;
        if (state_q == RUN) begin
            if (decoRedirect) begin
                pc_d = decoTarget;
            end else if (!stall && !halt) begin
                pc_d = pc_q + STEP_W;
            end
        end
    end

    // Output logic. All strobes are qualified by RUN, which masks requests
    // arriving while idle or halted.
    always_comb begin
        pc          = pc_q;
        fetch_en    = (state_q == RUN);
        redirect    = (state_q == RUN) && decoRedirect;
        illegal     = (state_q == RUN) && decoIllegal;
        misaligned  = (state_q == RUN) && decoMisaligned;
        flush_if_id = redirect;
        flush_id_ex = redirect;
    end

`ifdef PC_PERF_CNT_EN
    logic [15:0] redirectCnt_q;
    logic [15:0] stallCnt_q;
    logic        stallEvent;

    assign stallEvent = (state_q == RUN) && stall && !decoRedirect;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirectCnt_q <= '0;
            stallCnt_q    <= '0;
        end else begin
            if (redirect && (redirectCnt_q != 16'hFFFF)) begin
                redirectCnt_q <= redirectCnt_q + 16'd1;
            end
            if (stallEvent && (stallCnt_q != 16'hFFFF)) begin
                stallCnt_q <= stallCnt_q + 16'd1;
            end
        end
    end

    assign redirect_cnt = redirectCnt_q;
    assign stall_cnt    = stallCnt_q;
`endif

endmodule
